// File: rtl/vram_arbiter.sv
// Time-slot scheduler for the shared 8-bit VRAM port: slot 0 video read, slots 1..3 drain a CPU write FIFO.
// Optional VRAM_BLANK_SLOT_EN: slot 0 becomes a fourth write slot whenever fetchEn is low.
module vram_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        pixClk,
  input  logic        reset,
  input  logic [3:0]  seq,
  input  logic        fetchEn,
  input  logic [14:0] vidAddr,
  input  logic        vidBank,
  input  logic        wrReq,
  input  logic [14:0] wrAddr,
  input  logic [7:0]  wrData,
  input  logic        wrBank,
  output logic        wrRdy,
  output logic        wrOvf,
  output logic [14:0] vramAddr,
  output logic [7:0]  vramDataOut,
  output logic        vramDataOE,
  output logic        nvramOE,
  output logic        nvramWE,
  output logic        nvramCE0,
  output logic        nvramCE1
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic        bank;
    logic [14:0] addr;
    logic [7:0]  data;
  } wr_ent_t;

  typedef enum logic [1:0] {S_IDLE, S_VREAD, S_WRITE} state_t;

  wr_ent_t       r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  state_t        r_state;
  logic [3:0]    r_seqPrev;
  wr_ent_t       r_wr;

  logic [1:0]  w_ph;
  logic        w_seqOk, w_empty, w_push, w_pop, w_wslot;
  state_t      w_cur, w_act, w_next;
  wr_ent_t     w_wr;
  logic        w_nOE, w_nWE, w_nCE0, w_nCE1, w_dOE;
  logic [14:0] w_addr;
  logic [7:0]  w_dout;

  assign w_ph    = seq[1:0];
  assign w_seqOk = (seq == r_seqPrev + 4'd1);
  assign w_empty = (r_cnt == '0);
  assign wrRdy   = (r_cnt != CW'(FIFO_DEPTH));
  assign w_push  = wrReq && wrRdy;

`ifdef VRAM_BLANK_SLOT_EN
  assign w_wslot = (seq[3:2] != 2'd0) || !fetchEn;
`else
  assign w_wslot = (seq[3:2] != 2'd0);
`endif

  // State register
  always_ff @(negedge pixClk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_seqPrev <= 4'd0;
    end else begin
      r_state   <= w_next;
      r_seqPrev <= seq;
    end
  end

  // Next state. A resync (non-sequential seq) drops a busy slot; a new one may only begin on a boundary.
  always_comb begin
    w_cur = (r_state != S_IDLE && !w_seqOk) ? S_IDLE : r_state;
    w_act = w_cur;
    if (w_cur == S_IDLE && w_ph == 2'd0) begin
      if (seq == 4'd0 && fetchEn)   w_act = S_VREAD;
      else if (w_wslot && !w_empty) w_act = S_WRITE;
    end
    w_next = (w_ph == 2'd3) ? S_IDLE : w_act;
  end

  assign w_pop = (w_act == S_WRITE) && (w_cur == S_IDLE);
  assign w_wr  = w_pop ? r_mem[r_rp] : r_wr;

  // Output decode for the phase being entered this edge
  always_comb begin
    w_nOE  = 1'b1;
    w_nWE  = 1'b1;
    w_nCE0 = 1'b1;
    w_nCE1 = 1'b1;
    w_dOE  = 1'b0;
    w_addr = vramAddr;
    w_dout = vramDataOut;
    case (w_act)
      S_VREAD: begin
        w_addr = vidAddr;
        if (!w_ph[1]) begin
          w_nOE = 1'b0;
          if (vidBank) w_nCE1 = 1'b0;
          else         w_nCE0 = 1'b0;
        end
      end
      S_WRITE: begin
        w_addr = w_wr.addr;
        w_dout = w_wr.data;
        w_dOE  = 1'b1;
        if (w_ph != 2'd3) begin
          if (w_wr.bank) w_nCE1 = 1'b0;
          else           w_nCE0 = 1'b0;
        end
        if (w_ph == 2'd1 || w_ph == 2'd2) w_nWE = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(negedge pixClk) begin
    if (reset) begin
      nvramOE     <= 1'b1;
      nvramWE     <= 1'b1;
      nvramCE0    <= 1'b1;
      nvramCE1    <= 1'b1;
      vramDataOE  <= 1'b0;
      vramAddr    <= '0;
      vramDataOut <= '0;
      r_wr        <= '0;
    end else begin
      nvramOE     <= w_nOE;
      nvramWE     <= w_nWE;
      nvramCE0    <= w_nCE0;
      nvramCE1    <= w_nCE1;
      vramDataOE  <= w_dOE;
      vramAddr    <= w_addr;
      vramDataOut <= w_dout;
      if (w_pop) r_wr <= r_mem[r_rp];
    end
  end

  always_ff @(negedge pixClk) begin
    if (w_push) r_mem[r_wp] <= '{bank: wrBank, addr: wrAddr, data: wrData};
  end

  // A request while full is lost even if a pop frees space on the same edge
  always_ff @(negedge pixClk) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      wrOvf <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
      if (wrReq && !wrRdy) wrOvf <= 1'b1;
    end
  end

endmodule
